// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the LIF spiking core.
package snn_pkg;

  localparam int W_W_DEF     = 8;
  localparam int MEM_W_DEF   = 12;
  localparam int LEAK_SH_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIRE  = 2'd2
  } state_e;

  // Signed add clamped to a w-bit two's complement range; operands must fit well inside int.
  function automatic int sat_add(input int a, input int b, input int w);
    int s;
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    s  = a + b;
    if (s > hi)      sat_add = hi;
    else if (s < lo) sat_add = lo;
    else             sat_add = s;
  endfunction

endpackage

// File: rtl/snn_lif_neuron.sv
// One leaky integrate-and-fire neuron: membrane register, leak, threshold compare.
// SNN_REFRACTORY_EN adds a one-step refractory flag after each spike.
module snn_lif_neuron
  import snn_pkg::*;
#(
  parameter int MEM_W   = MEM_W_DEF,
  parameter int LEAK_SH = LEAK_SH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    add_en,
  input  logic signed [MEM_W-1:0] add_val,
  input  logic                    fire_en,
  input  logic signed [MEM_W-1:0] thresh,
  output logic                    spike
);

  logic signed [MEM_W-1:0] mem;
  logic signed [MEM_W-1:0] acc;
  logic signed [MEM_W-1:0] v;
  logic                    refr;

  always_comb begin
    acc   = MEM_W'(sat_add(int'(mem), int'(add_val), MEM_W));
    v     = MEM_W'(sat_add(int'(mem), -int'(mem >>> LEAK_SH), MEM_W));
    spike = !refr && (v >= thresh);
  end

`ifdef SNN_REFRACTORY_EN
  // Set by a spike, cleared by the following FIRE (where spike is forced low).
  always_ff @(posedge clk) begin
    if (!rst_n)       refr <= 1'b0;
    else if (fire_en) refr <= spike;
  end
`else
  assign refr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)                 mem <= '0;
    else if (fire_en)           mem <= (spike || refr) ? '0 : v;
    else if (add_en && !refr)   mem <= acc;
  end

endmodule

// File: rtl/snn_lif_core.sv
// Fully-connected LIF layer: weight flop array, IDLE/ACCUM/FIRE sequencer, N_OUT neurons.
// Optional refractory behaviour is selected with SNN_REFRACTORY_EN.
module snn_lif_core
  import snn_pkg::*;
#(
  parameter int N_IN    = 8,
  parameter int N_OUT   = 8,
  parameter int W_W     = W_W_DEF,
  parameter int MEM_W   = MEM_W_DEF,
  parameter int LEAK_SH = LEAK_SH_DEF,
  localparam int N_W    = N_IN * N_OUT,
  localparam int ADDR_W = $clog2(N_W),
  localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    cfg_valid_i,
  input  logic [ADDR_W-1:0]       cfg_addr_i,
  input  logic signed [W_W-1:0]   cfg_data_i,
  output logic                    cfg_ready_o,
  input  logic signed [MEM_W-1:0] thresh_i,
  input  logic                    step_i,
  input  logic [N_IN-1:0]         spk_in_i,
  output logic [N_OUT-1:0]        spk_out_o,
  output logic                    busy_o,
  output logic                    done_o
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    in_idx;
  logic [N_IN-1:0]     spk_q;
  logic [N_OUT-1:0]    spikes;
  logic                accum_add;
  logic                fire_en;
  logic signed [W_W-1:0] wmem [N_W];

  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign fire_en     = (state_q == FIRE);
  assign accum_add   = (state_q == ACCUM) && spk_q[in_idx];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (step_i) state_d = ACCUM;
      ACCUM:   if (in_idx == IDX_W'(N_IN - 1)) state_d = FIRE;
      FIRE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= IDLE;
      in_idx    <= '0;
      spk_q     <= '0;
      spk_out_o <= '0;
      done_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_o  <= fire_en;
      if (state_q == IDLE && step_i) begin
        spk_q  <= spk_in_i;
        in_idx <= '0;
      end
      if (state_q == ACCUM) in_idx <= in_idx + 1'b1;
      if (fire_en)          spk_out_o <= spikes;
    end
  end

  // Writes only land in IDLE, so a step launched in the same cycle sees the new weight.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      for (int k = 0; k < N_W; k++) wmem[k] <= '0;
    end else if (cfg_ready_o && cfg_valid_i && (int'(cfg_addr_i) < N_W)) begin
      wmem[cfg_addr_i] <= cfg_data_i;
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_nrn
    logic [ADDR_W-1:0]       w_idx;
    logic signed [MEM_W-1:0] w_ext;

    assign w_idx = ADDR_W'(int'(in_idx) * N_OUT + j);
    assign w_ext = MEM_W'(wmem[w_idx]);

    snn_lif_neuron #(
      .MEM_W   (MEM_W),
      .LEAK_SH (LEAK_SH)
    ) u_nrn (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_n_i),
      .add_en  (accum_add),
      .add_val (w_ext),
      .fire_en (fire_en),
      .thresh  (thresh_i),
      .spike   (spikes[j])
    );
  end

endmodule
